multicycle_control_unit: RTL and testbench

//  Main FSM controller for the multicycle RV32I datapath (shared ALU, unified instr/data memory).

---
 rtl/rv_ctrl_pkg.sv | 139 +++++++++++++
 rtl/multicycle_control_unit_decoder.sv | 39 +++
 rtl/multicycle_control_unit.sv | 116 +++++++++++
 tb/tb_multicycle_control_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg
// Shared definitions for the multicycle RV32I controller and its datapath:
// FSM state encoding, RV32I opcode constants, and the mux select encodings.
// Also provides the per-state control bundle that the FSM registers.
// No ports; it is imported by the controller, the decoder and the datapath.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_ALUWB    = 4'd9,
    S_JAL      = 4'd10,
    S_BEQ      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALU_A_PC    = 2'b00;
  localparam logic [1:0] ALU_A_OLDPC = 2'b01;
  localparam logic [1:0] ALU_A_RS1   = 2'b10;

  localparam logic [1:0] ALU_B_RS2  = 2'b00;
  localparam logic [1:0] ALU_B_IMM  = 2'b01;
  localparam logic [1:0] ALU_B_FOUR = 2'b10;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  // Registered control bundle. in_fetch/pc_update/branch are not outputs
  // themselves; they are combined with mem_ready and zero at the top level.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       reg_write;
    logic       in_fetch;
    logic       pc_update;
    logic       branch;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  // Moore control values for a state; anything not set stays 0.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.in_fetch   = 1'b1;
        c.alu_src_a  = ALU_A_PC;
        c.alu_src_b  = ALU_B_FOUR;
        c.alu_op     = ALU_OP_ADD;
        c.result_src = RES_ALU;
      end
      S_DECODE: begin
        c.alu_src_a = ALU_A_OLDPC;
        c.alu_src_b = ALU_B_IMM;
        c.alu_op    = ALU_OP_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = ALU_A_RS1;
        c.alu_src_b = ALU_B_IMM;
        c.alu_op    = ALU_OP_ADD;
      end
      S_MEMREAD: begin
        c.mem_req    = 1'b1;
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        c.result_src = RES_MEM;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_req    = 1'b1;
        c.mem_write  = 1'b1;
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      S_EXEC_R: begin
        c.alu_src_a = ALU_A_RS1;
        c.alu_src_b = ALU_B_RS2;
        c.alu_op    = ALU_OP_FUNCT;
      end
      S_EXEC_I: begin
        c.alu_src_a = ALU_A_RS1;
        c.alu_src_b = ALU_B_IMM;
        c.alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a  = ALU_A_OLDPC;
        c.alu_src_b  = ALU_B_FOUR;
        c.alu_op     = ALU_OP_ADD;
        c.result_src = RES_ALUOUT;
        c.pc_update  = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = ALU_A_RS1;
        c.alu_src_b  = ALU_B_RS2;
        c.alu_op     = ALU_OP_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_decoder.sv
// ctrl_opcode_decoder
// Combinational opcode classifier for the multicycle controller.
// Ports: opcode (in, 7) -> is_load, is_store, is_r, is_i, is_br, is_jal,
//        legal (any supported opcode), imm_src (immediate format select).
// JAL only counts as legal when SUPPORT_JAL is set; its J immediate format
// is decoded regardless, since imm_src is a pure function of the opcode.
module ctrl_opcode_decoder
  import rv_ctrl_pkg::*;
#(
  parameter bit SUPPORT_JAL = 1'b1
) (
  input  logic [6:0] opcode,
  output logic       is_load,
  output logic       is_store,
  output logic       is_r,
  output logic       is_i,
  output logic       is_br,
  output logic       is_jal,
  output logic       legal,
  output logic [2:0] imm_src
);

  always_comb begin
    is_load  = (opcode == OP_LW);
    is_store = (opcode == OP_SW);
    is_r     = (opcode == OP_R);
    is_i     = (opcode == OP_I);
    is_br    = (opcode == OP_BEQ);
    is_jal   = SUPPORT_JAL && (opcode == OP_JAL);
    legal    = is_load | is_store | is_r | is_i | is_br | is_jal;
    case (opcode)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Main FSM of the multicycle RV32I datapath (shared ALU, unified memory).
// Ports: clk, rst_n (async active-low); opcode, zero, mem_ready in;
//        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
//        alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal_op,
//        instret (retired instruction count, CNT_W bits) out.
// Control outputs are registered from the next state; only ir_write and
// pc_write additionally depend on mem_ready/zero in the current cycle.
module multicycle_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter bit SUPPORT_JAL = 1'b1,
  parameter bit MEM_HS      = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic [2:0]       imm_src,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret
);

  state_t state, next_state;
  ctrl_t  ctrl_q;
  logic   rdy, retire;
  logic   is_load, is_store, is_r, is_i, is_br, is_jal, legal;

  ctrl_opcode_decoder #(.SUPPORT_JAL(SUPPORT_JAL)) u_dec (
    .opcode  (opcode),
    .is_load (is_load),
    .is_store(is_store),
    .is_r    (is_r),
    .is_i    (is_i),
    .is_br   (is_br),
    .is_jal  (is_jal),
    .legal   (legal),
    .imm_src (imm_src)
  );

  // Without the handshake every memory access completes in one cycle.
  assign rdy = mem_ready | ~MEM_HS;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     next_state = S_FETCH;
      S_FETCH:    if (rdy) next_state = S_DECODE;
      S_DECODE: begin
        if (!legal)                 next_state = S_TRAP;
        else if (is_load | is_store) next_state = S_MEMADR;
        else if (is_r)              next_state = S_EXEC_R;
        else if (is_i)              next_state = S_EXEC_I;
        else if (is_br)             next_state = S_BEQ;
        else                        next_state = S_JAL;
      end
      S_MEMADR:   next_state = is_load ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (rdy) next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: if (rdy) next_state = S_FETCH;
      S_EXEC_R:   next_state = S_ALUWB;
      S_EXEC_I:   next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      S_BEQ:      next_state = S_FETCH;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_IDLE;
    endcase
  end

  // An instruction retires when its last state hands back to FETCH; a
  // FETCH that keeps waiting is not a retirement.
  assign retire = (next_state == S_FETCH) &&
                  (state == S_MEMWB || state == S_MEMWRITE ||
                   state == S_ALUWB || state == S_BEQ);

  // State, registered controls, sticky trap flag and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ctrl_q     <= '0;
      illegal_op <= 1'b0;
      instret    <= '0;
    end else begin
      state  <= next_state;
      ctrl_q <= state_ctrl(next_state);
      if (next_state == S_TRAP) illegal_op <= 1'b1;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  assign mem_req    = ctrl_q.mem_req;
  assign mem_write  = ctrl_q.mem_write;
  assign adr_src    = ctrl_q.adr_src;
  assign reg_write  = ctrl_q.reg_write;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign result_src = ctrl_q.result_src;
  assign ir_write   = ctrl_q.in_fetch & rdy;
  assign pc_write   = (ctrl_q.in_fetch & rdy) | ctrl_q.pc_update |
                      (ctrl_q.branch & zero);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit
// Drives two controller builds: dut_a (JAL, handshake, 32-bit counter) and
// dut_b (no JAL, no handshake, 4-bit counter). Each instruction is replayed
// against an instruction-level timeline of expected control words, with
// random memory wait lengths, random zero flag and random opcode mix.
module tb_multicycle_control_unit;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RR  = 7'b0110011;
  localparam logic [6:0] II  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk;
  logic       rst_na, rst_nb;
  logic [6:0] opcode;
  logic       zero, mem_ready;
  logic       sel;

  logic        a_mem_req, a_mem_write, a_adr_src, a_ir_write, a_pc_write, a_reg_write, a_illegal;
  logic [1:0]  a_src_a, a_src_b, a_alu_op, a_res;
  logic [2:0]  a_imm;
  logic [31:0] a_instret;
  logic        b_mem_req, b_mem_write, b_adr_src, b_ir_write, b_pc_write, b_reg_write, b_illegal;
  logic [1:0]  b_src_a, b_src_b, b_alu_op, b_res;
  logic [2:0]  b_imm;
  logic [3:0]  b_instret;

  logic [14:0] obs_vec;
  logic [2:0]  obs_imm;
  logic [31:0] obs_cnt;

  int          checks, errors;
  int unsigned model_cnt;

  multicycle_control_unit #(.SUPPORT_JAL(1'b1), .MEM_HS(1'b1), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_na), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .mem_write(a_mem_write), .adr_src(a_adr_src),
    .ir_write(a_ir_write), .pc_write(a_pc_write), .reg_write(a_reg_write),
    .alu_src_a(a_src_a), .alu_src_b(a_src_b), .alu_op(a_alu_op), .result_src(a_res),
    .imm_src(a_imm), .illegal_op(a_illegal), .instret(a_instret)
  );

  multicycle_control_unit #(.SUPPORT_JAL(1'b0), .MEM_HS(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_nb), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .mem_write(b_mem_write), .adr_src(b_adr_src),
    .ir_write(b_ir_write), .pc_write(b_pc_write), .reg_write(b_reg_write),
    .alu_src_a(b_src_a), .alu_src_b(b_src_b), .alu_op(b_alu_op), .result_src(b_res),
    .imm_src(b_imm), .illegal_op(b_illegal), .instret(b_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe whichever build is currently under test.
  always_comb begin
    if (sel) begin
      obs_vec = {b_mem_req, b_mem_write, b_adr_src, b_ir_write, b_pc_write, b_reg_write,
                 b_src_a, b_src_b, b_alu_op, b_res, b_illegal};
      obs_imm = b_imm;
      obs_cnt = {28'd0, b_instret};
    end else begin
      obs_vec = {a_mem_req, a_mem_write, a_adr_src, a_ir_write, a_pc_write, a_reg_write,
                 a_src_a, a_src_b, a_alu_op, a_res, a_illegal};
      obs_imm = a_imm;
      obs_cnt = a_instret;
    end
  end

  function automatic logic [14:0] outv(input logic mreq, input logic mwr, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic [1:0] res,
                                       input logic ill);
    return {mreq, mwr, adr, irw, pcw, rw, a, b, op, res, ill};
  endfunction

  function automatic logic [2:0] immModel(input logic [6:0] op);
    case (op)
      SW:      return 3'b001;
      BEQ:     return 3'b010;
      JAL:     return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int unsigned cntMask();
    return sel ? 32'h0000_000F : 32'hFFFF_FFFF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // One clock cycle: drive inputs, check controls/imm/count, then advance.
  task automatic applyStimulus(input string tag, input logic ready, input logic z,
                               input logic [14:0] expv, input logic retire);
    mem_ready = ready;
    zero      = z;
    #1;
    checkOutput({tag, " ctl"}, 32'(obs_vec), 32'(expv));
    checkOutput({tag, " imm"}, 32'(obs_imm), 32'(immModel(opcode)));
    checkOutput({tag, " instret"}, obs_cnt, model_cnt);
    @(posedge clk);
    #1;
    if (retire) model_cnt = (model_cnt + 1) & cntMask();
  endtask

  task automatic applyReset();
    if (sel) rst_nb = 1'b0;
    else     rst_na = 1'b0;
    mem_ready = 1'b0;
    #1;
    checkOutput("reset ctl", 32'(obs_vec), 32'd0);
    checkOutput("reset instret", obs_cnt, 32'd0);
    checkOutput("reset imm", 32'(obs_imm), 32'(immModel(opcode)));
    model_cnt = 0;
    @(posedge clk);
    #1;
    if (sel) rst_nb = 1'b1;
    else     rst_na = 1'b1;
    applyStimulus("idle", 1'($urandom), 1'($urandom), 15'd0, 1'b0);
  endtask

  // Memory phase: ready rises after 'waits' cycles; without the handshake
  // the first cycle already completes.
  task automatic memPhase(input string tag, input int waits, input logic [14:0] base,
                          input logic is_fetch, input logic retire_on_done);
    logic r, g;
    logic [14:0] e;
    for (int i = 0; i <= waits; i++) begin
      r = (i == waits);
      g = r | sel;
      e = base;
      if (is_fetch) e[11:10] = {g, g};
      applyStimulus(tag, r, 1'($urandom), e, retire_on_done & g);
      if (g) break;
    end
  endtask

  task automatic runInstr(input logic [6:0] op, input logic z, input int w1, input int w2,
                          output logic trapped);
    logic jal_ok;
    jal_ok  = !sel;
    trapped = 1'b0;
    opcode  = op;
    memPhase("fetch", w1, outv(1,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0), 1'b1, 1'b0);
    applyStimulus("decode", 1'($urandom), 1'($urandom), outv(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0), 1'b0);
    if (op == LW) begin
      applyStimulus("memadr", 1'($urandom), 1'($urandom), outv(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0), 1'b0);
      memPhase("memread", w2, outv(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0), 1'b0, 1'b0);
      applyStimulus("memwb", 1'($urandom), 1'($urandom), outv(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b01,0), 1'b1);
    end else if (op == SW) begin
      applyStimulus("memadr", 1'($urandom), 1'($urandom), outv(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0), 1'b0);
      memPhase("memwrite", w2, outv(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0), 1'b0, 1'b1);
    end else if (op == RR || op == II) begin
      applyStimulus("exec", 1'($urandom), 1'($urandom),
                    outv(0,0,0,0,0,0,2'b10,(op == II) ? 2'b01 : 2'b00,2'b10,2'b00,0), 1'b0);
      applyStimulus("aluwb", 1'($urandom), 1'($urandom), outv(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0), 1'b1);
    end else if (op == BEQ) begin
      applyStimulus("beq", 1'($urandom), z, outv(0,0,0,0,z,0,2'b10,2'b00,2'b01,2'b00,0), 1'b1);
    end else if (op == JAL && jal_ok) begin
      applyStimulus("jal", 1'($urandom), 1'($urandom), outv(0,0,0,0,1,0,2'b01,2'b10,2'b00,2'b00,0), 1'b0);
      applyStimulus("jal wb", 1'($urandom), 1'($urandom), outv(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0), 1'b1);
    end else begin
      for (int i = 0; i < 3; i++)
        applyStimulus("trap", 1'($urandom), 1'($urandom), outv(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1), 1'b0);
      trapped = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic       t;
    logic [6:0] ops [6];
    ops = '{LW, SW, RR, II, BEQ, JAL};
    checks = 0; errors = 0; model_cnt = 0;
    sel = 1'b0; rst_na = 1'b0; rst_nb = 1'b0;
    opcode = SW; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Full-featured build.
    applyReset();
    runInstr(LW, 1'b0, 0, 0, t);
    runInstr(SW, 1'b0, 0, 3, t);
    runInstr(BEQ, 1'b1, 1, 0, t);
    runInstr(BEQ, 1'b0, 0, 0, t);
    runInstr(JAL, 1'b0, 2, 0, t);
    for (int n = 0; n < 30; n++)
      runInstr(ops[$urandom_range(0, 5)], 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), t);

    // Reset while a load is waiting on memory.
    opcode = LW;
    memPhase("fetch", 0, outv(1,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0), 1'b1, 1'b0);
    applyStimulus("decode", 1'b1, 1'b0, outv(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0), 1'b0);
    applyStimulus("memadr", 1'b1, 1'b0, outv(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0), 1'b0);
    applyStimulus("memread wait", 1'b0, 1'b0, outv(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0), 1'b0);
    applyReset();

    runInstr(BAD, 1'b0, 0, 0, t);
    checkOutput("trap taken", 32'(t), 32'd1);
    applyReset();
    runInstr(II, 1'b0, 0, 0, t);

    // Build without JAL and without memory handshake, 4-bit counter.
    sel = 1'b1;
    applyReset();
    for (int n = 0; n < 16; n++)
      runInstr(II, 1'($urandom), $urandom_range(1, 2), 0, t);
    runInstr(LW, 1'b0, 1, 2, t);
    runInstr(SW, 1'b0, 0, 3, t);
    runInstr(JAL, 1'b0, 0, 0, t);
    checkOutput("jal trap", 32'(t), 32'd1);
    applyReset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
